// File: rtl/borrow_look_ahead_subtractor_pipe_pkg.sv
// borrow_look_ahead_subtractor_pipe_pkg
//   Shared constants and helpers for the pipelined borrow-look-ahead subtractor.
//   GRP_W      : width of one look-ahead group (one pipeline stage per group)
//   width_ok() : legality check for the subtractor width (multiple of GRP_W, >= GRP_W)
//   num_stg()  : number of pipeline stages for a given width
package borrow_look_ahead_subtractor_pipe_pkg;

    localparam int unsigned GRP_W = 4;

    function automatic bit width_ok(input int unsigned w);
        return (w >= GRP_W) && ((w % GRP_W) == 0);
    endfunction

    function automatic int unsigned num_stg(input int unsigned w);
        return w / GRP_W;
    endfunction

endpackage

// File: rtl/borrow_look_ahead_subtractor_pipe_bla4.sv
// borrow_look_ahead_4
//   Combinational 4-bit borrow-look-ahead subtractor group: d = a - b - bin.
//   Every internal borrow is a flat two-level sum of products of the bit
//   generate (g = ~a & b) and propagate (p = ~(a ^ b)) terms, so there is no
//   ripple inside the group.
// Ports
//   a    in  [3:0]  minuend nibble
//   b    in  [3:0]  subtrahend nibble
//   bin  in         borrow into bit 0
//   d    out [3:0]  difference nibble
//   bout out        borrow out of bit 3
module borrow_look_ahead_4
    import borrow_look_ahead_subtractor_pipe_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             bin,
    output logic [GRP_W-1:0] d,
    output logic             bout
);

    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] br;   // borrow into each bit position

    assign g = ~a & b;
    assign p = ~(a ^ b);

    assign br[0] = bin;
    assign br[1] = g[0]
                 | (p[0] & bin);
    assign br[2] = g[1]
                 | (p[1] & g[0])
                 | (p[1] & p[0] & bin);
    assign br[3] = g[2]
                 | (p[2] & g[1])
                 | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bin);
    assign bout  = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d = a ^ b ^ br;

endmodule

// File: rtl/borrow_look_ahead_subtractor_pipe.sv
// borrow_look_ahead_subtractor_pipe
//   Pipelined WIDTH-bit subtractor diff = a - b - bin (mod 2^WIDTH) built from
//   4-bit borrow-look-ahead groups, one pipeline stage per group. Stage k holds
//   a beat whose groups below k are already difference bits and whose groups
//   k and above are still minuend bits, plus the registered borrow into group k.
//   A single global advance (adv = ~out_valid | out_ready) shifts every stage;
//   empty stages travel as bubbles (valid = 0).
//   Latency: NSTG cycles from the accept edge to out_valid; throughput 1/cycle.
// Optional feature
//   SUB_OVF_FLAG_EN : when defined, adds the signed-overflow output ovf and the
//                     a/b MSB sideband registers that feed it.
// Ports
//   clk       in             rising-edge clock
//   rst_n     in             asynchronous active-low reset
//   in_valid  in             operand beat valid
//   in_ready  out            operand beat accepted this cycle when in_valid
//   a         in  [WIDTH]    minuend
//   b         in  [WIDTH]    subtrahend
//   bin       in             borrow-in
//   out_valid out            result beat valid
//   out_ready in             downstream accepts result
//   diff      out [WIDTH]    a - b - bin
//   bout      out            unsigned borrow-out (a < b + bin)
//   zero      out            diff == 0
//   ovf       out            signed overflow (SUB_OVF_FLAG_EN only)
module borrow_look_ahead_subtractor_pipe
    import borrow_look_ahead_subtractor_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NSTG = num_stg(WIDTH);
    localparam int unsigned LAST = NSTG - 1;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("borrow_look_ahead_subtractor_pipe: WIDTH must be a multiple of 4 and >= 4");
    end

    logic              adv;

    // Stage registers
    logic [NSTG-1:0]   stg_v;
    logic [WIDTH-1:0]  stg_x  [NSTG];   // lower groups: diff, upper groups: minuend
    logic [WIDTH-1:0]  stg_b  [NSTG];   // subtrahend travels unchanged
    logic [NSTG-1:0]   stg_br;          // registered borrow into group k
`ifdef SUB_OVF_FLAG_EN
    logic [NSTG-1:0]   stg_am;          // minuend MSB sideband
    logic [NSTG-1:0]   stg_bm;          // subtrahend MSB sideband
`endif

    // Per-stage combinational results
    logic [GRP_W-1:0]  grp_d  [NSTG];
    logic [NSTG-1:0]   grp_bo;
    logic [WIDTH-1:0]  stg_nx [NSTG];   // stage word with its own group replaced by diff

    logic [WIDTH-1:0]  fin_diff;
    logic              fin_zero;
`ifdef SUB_OVF_FLAG_EN
    logic              fin_ovf;
`endif

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_grp
        borrow_look_ahead_4 u_bla (
            .a    (stg_x[k][k*GRP_W +: GRP_W]),
            .b    (stg_b[k][k*GRP_W +: GRP_W]),
            .bin  (stg_br[k]),
            .d    (grp_d[k]),
            .bout (grp_bo[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < NSTG; k++) begin
            stg_nx[k] = stg_x[k];
            stg_nx[k][k*GRP_W +: GRP_W] = grp_d[k];
        end
    end

    assign fin_diff = stg_nx[LAST];
    assign fin_zero = ~|fin_diff;
`ifdef SUB_OVF_FLAG_EN
    assign fin_ovf  = (stg_am[LAST] ^ stg_bm[LAST]) & (stg_am[LAST] ^ fin_diff[WIDTH-1]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_v     <= '0;
            stg_br    <= '0;
            for (int unsigned k = 0; k < NSTG; k++) begin
                stg_x[k] <= '0;
                stg_b[k] <= '0;
            end
`ifdef SUB_OVF_FLAG_EN
            stg_am    <= '0;
            stg_bm    <= '0;
            ovf       <= 1'b0;
`endif
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            // Stage 0 captures the raw operands; a bubble is simply valid = 0.
            stg_v[0]  <= in_valid;
            stg_x[0]  <= a;
            stg_b[0]  <= b;
            stg_br[0] <= bin;
`ifdef SUB_OVF_FLAG_EN
            stg_am[0] <= a[WIDTH-1];
            stg_bm[0] <= b[WIDTH-1];
`endif
            for (int unsigned k = 1; k < NSTG; k++) begin
                stg_v[k]  <= stg_v[k-1];
                stg_x[k]  <= stg_nx[k-1];
                stg_b[k]  <= stg_b[k-1];
                stg_br[k] <= grp_bo[k-1];
`ifdef SUB_OVF_FLAG_EN
                stg_am[k] <= stg_am[k-1];
                stg_bm[k] <= stg_bm[k-1];
`endif
            end
            // Output data only moves when a real beat leaves the last stage,
            // so the result registers never pick up bubble contents.
            out_valid <= stg_v[LAST];
            if (stg_v[LAST]) begin
                diff <= fin_diff;
                bout <= grp_bo[LAST];
                zero <= fin_zero;
`ifdef SUB_OVF_FLAG_EN
                ovf  <= fin_ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_borrow_look_ahead_subtractor_pipe.sv
// tb_borrow_look_ahead_subtractor_pipe
//   Self-checking bench for borrow_look_ahead_subtractor_pipe at WIDTH = 16.
//   Define SUB_OVF_FLAG_EN to also check the ovf output.
module tb_borrow_look_ahead_subtractor_pipe;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
`ifdef SUB_OVF_FLAG_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         z;
        logic         ov;
    } exp_t;

    exp_t        expq[$];
    int unsigned nvec = 0;
    int unsigned nerr = 0;

    always #5 clk = ~clk;

    borrow_look_ahead_subtractor_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero)
`ifdef SUB_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        int   ux, uy, r, sx, sy, sr;
        ux   = int'(x);
        uy   = int'(y);
        r    = ux - uy - int'(c);
        e.d  = r[W-1:0];
        e.bo = (ux < uy + int'(c));
        e.z  = (e.d == '0);
        sx   = int'($signed(x));
        sy   = int'($signed(y));
        sr   = sx - sy - int'(c);
        e.ov = (sr < -32768) || (sr > 32767);
        return e;
    endfunction

    // One clock cycle: drive inputs on the falling edge, then report whether
    // the next rising edge accepts an operand and/or transfers a result.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input logic ordy, output logic acc, output logic txn);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
        #1;
        acc = iv & in_ready;
        txn = out_valid & ordy;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        #12;
        nvec++;
        if (out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0 || zero !== 1'b0) begin
            nerr++;
            $display("FAIL reset_outputs: got out_valid=%b diff=%h bout=%b zero=%b, want 0 0000 0 0",
                     out_valid, diff, bout, zero);
        end
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
`ifdef SUB_OVF_FLAG_EN
        nvec++;
        if (ovf !== 1'b0) begin
            nerr++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta  [7] = '{16'h1234, 16'h0000, 16'h0010, 16'h0005, 16'h8000, 16'h7FFF, 16'h0003};
        logic [W-1:0] tb_ [7] = '{16'h0034, 16'h0001, 16'h000F, 16'h0006, 16'h0001, 16'hFFFF, 16'h0001};
        logic         tc  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] td  [7] = '{16'h1200, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0002};
        logic         tbo [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic         tz  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic         tov [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic acc, txn, found;
        int   lat;
        for (int v = 0; v < 7; v++) begin
            step(1'b1, ta[v], tb_[v], tc[v], 1'b1, acc, txn);
            nvec++;
            if (acc !== 1'b1) begin
                nerr++;
                $display("FAIL dir%0d_accept: got %b want 1", v, acc);
            end
            found = 1'b0;
            lat   = -1;
            for (int i = 1; i <= 12; i++) begin
                step(1'b0, '0, '0, 1'b0, 1'b1, acc, txn);
                if (out_valid === 1'b1) begin
                    found = 1'b1;
                    lat   = i - 1;
                    break;
                end
            end
            nvec++;
            if (!found) begin
                nerr++;
                $display("FAIL dir%0d_timeout: out_valid never rose within 12 cycles, want 4", v);
            end else begin
                if (lat != 4) begin
                    nerr++;
                    $display("FAIL dir%0d_latency: got %0d cycles want 4", v, lat);
                end
                nvec++;
                if (diff !== td[v] || bout !== tbo[v] || zero !== tz[v]) begin
                    nerr++;
                    $display("FAIL dir%0d_result: got diff=%h bout=%b zero=%b want diff=%h bout=%b zero=%b",
                             v, diff, bout, zero, td[v], tbo[v], tz[v]);
                end
`ifdef SUB_OVF_FLAG_EN
                nvec++;
                if (ovf !== tov[v]) begin
                    nerr++;
                    $display("FAIL dir%0d_ovf: got %b want %b", v, ovf, tov[v]);
                end
`else
                if (tov[v] === 1'bx) $display("unreachable");
`endif
            end
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, acc, txn);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ba [8];
        logic [W-1:0] bb [8];
        logic         bc [8];
        logic [W-1:0] prev_d;
        logic         prev_bo, prev_z;
        logic         acc, txn, ordy;
        int           idx, got;
        exp_t         e;
        for (int i = 0; i < 8; i++) begin
            ba[i] = W'($urandom);
            bb[i] = W'($urandom);
            bc[i] = 1'($urandom);
        end
        idx = 0;
        got = 0;
        expq.delete();
        prev_d  = '0;
        prev_bo = 1'b0;
        prev_z  = 1'b0;
        for (int j = 0; j < 60; j++) begin
            ordy = !(j >= 6 && j < 9);
            step(idx < 8, (idx < 8) ? ba[idx] : '0, (idx < 8) ? bb[idx] : '0,
                 (idx < 8) ? bc[idx] : 1'b0, ordy, acc, txn);
            if (j >= 6 && j < 9) begin
                nvec++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                    nerr++;
                    $display("FAIL b2b_stall_ready j=%0d: got out_valid=%b in_ready=%b want 1 0",
                             j, out_valid, in_ready);
                end
                if (j > 6) begin
                    nvec++;
                    if (diff !== prev_d || bout !== prev_bo || zero !== prev_z) begin
                        nerr++;
                        $display("FAIL b2b_stall_hold j=%0d: got diff=%h bout=%b zero=%b want %h %b %b",
                                 j, diff, bout, zero, prev_d, prev_bo, prev_z);
                    end
                end
            end
            prev_d  = diff;
            prev_bo = bout;
            prev_z  = zero;
            if (acc) begin
                expq.push_back(model(ba[idx], bb[idx], bc[idx]));
                idx++;
            end
            if (txn) begin
                nvec++;
                if (expq.size() == 0) begin
                    nerr++;
                    $display("FAIL b2b_extra: got diff=%h with no beat outstanding", diff);
                end else begin
                    e = expq.pop_front();
                    got++;
                    if (diff !== e.d || bout !== e.bo || zero !== e.z) begin
                        nerr++;
                        $display("FAIL b2b_result%0d: got diff=%h bout=%b zero=%b want diff=%h bout=%b zero=%b",
                                 got, diff, bout, zero, e.d, e.bo, e.z);
                    end
`ifdef SUB_OVF_FLAG_EN
                    nvec++;
                    if (ovf !== e.ov) begin
                        nerr++;
                        $display("FAIL b2b_ovf%0d: got %b want %b", got, ovf, e.ov);
                    end
`endif
                end
            end
            if (idx == 8 && got == 8) break;
        end
        nvec++;
        if (got != 8 || expq.size() != 0) begin
            nerr++;
            $display("FAIL b2b_count: got %0d results (%0d pending) want 8 (0 pending)", got, expq.size());
        end
    endtask

    task automatic test_random;
        logic [W-1:0] ra, rb;
        logic         rc, iv, ordy, acc, txn;
        exp_t         e;
        expq.delete();
        for (int j = 0; j < 420; j++) begin
            iv   = (j < 400) && ($urandom_range(9, 0) < 7);
            ordy = (j >= 400) || ($urandom_range(9, 0) < 7);
            ra   = W'($urandom);
            rb   = ($urandom_range(3, 0) == 0) ? ra : W'($urandom);
            rc   = 1'($urandom);
            step(iv, ra, rb, rc, ordy, acc, txn);
            if (acc) expq.push_back(model(ra, rb, rc));
            if (txn) begin
                nvec++;
                if (expq.size() == 0) begin
                    nerr++;
                    $display("FAIL rand_extra: got diff=%h with no beat outstanding", diff);
                end else begin
                    e = expq.pop_front();
                    if (diff !== e.d || bout !== e.bo || zero !== e.z) begin
                        nerr++;
                        $display("FAIL rand_result: got diff=%h bout=%b zero=%b want diff=%h bout=%b zero=%b",
                                 diff, bout, zero, e.d, e.bo, e.z);
                    end
`ifdef SUB_OVF_FLAG_EN
                    nvec++;
                    if (ovf !== e.ov) begin
                        nerr++;
                        $display("FAIL rand_ovf: got %b want %b", ovf, e.ov);
                    end
`endif
                end
            end
        end
        nvec++;
        if (expq.size() != 0) begin
            nerr++;
            $display("FAIL rand_drain: got %0d beats still pending want 0", expq.size());
        end
    endtask

    task automatic test_reset_flush;
        logic acc, txn, stale, found;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, W'(16'h00F0 + i), 16'h0001, 1'b0, 1'b1, acc, txn);
        end
        nvec++;
        if (out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL flush_precondition: got out_valid=%b want 1", out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0 || zero !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL flush_async: got out_valid=%b diff=%h bout=%b zero=%b in_ready=%b want 0 0000 0 0 1",
                     out_valid, diff, bout, zero, in_ready);
        end
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc, txn);
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        nvec++;
        if (stale) begin
            nerr++;
            $display("FAIL flush_stale: got out_valid=1 after reset release want 0");
        end
        step(1'b1, 16'h0002, 16'h0001, 1'b0, 1'b1, acc, txn);
        found = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc, txn);
            if (out_valid === 1'b1) begin
                found = 1'b1;
                lat   = i - 1;
                break;
            end
        end
        nvec++;
        if (!found || lat != 4 || diff !== 16'h0001 || bout !== 1'b0 || zero !== 1'b0) begin
            nerr++;
            $display("FAIL flush_next: got found=%b lat=%0d diff=%h bout=%b zero=%b want 1 4 0001 0 0",
                     found, lat, diff, bout, zero);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, acc, txn);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
